// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
// md_op_e is the encoding the decoder drives onto MDOp alongside Start.
package mult_div_unit_pkg;

  localparam int unsigned MdOpW = 4;

  typedef enum logic [MdOpW-1:0] {
    MdNone  = 4'd0,
    MdMult  = 4'd1,
    MdMultu = 4'd2,
    MdDiv   = 4'd3,
    MdDivu  = 4'd4,
    MdMthi  = 4'd5,
    MdMtlo  = 4'd6
  } md_op_e;

  typedef enum logic {
    StIdle,
    StRun
  } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit in the EX stage; owns the HI/LO registers.
// The 64-bit result is computed at the accepting edge and parked in pending
// registers; it is copied to HI/LO only when the fixed cycle count expires.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous, active-high; aborts any operation in flight
//   Start  - EX-stage MD op this cycle (single-cycle qualifier)
//   MDOp   - operation code (md_op_e); unknown codes do nothing
//   SrcA   - rs operand
//   SrcB   - rt operand
//   Busy   - registered, high for exactly MULT_CYCLES/DIV_CYCLES cycles
//   HI, LO - architectural HI/LO registers
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [MdOpW-1:0] MDOp,
  input  logic [31:0]      SrcA,
  input  logic [31:0]      SrcB,
  output logic             Busy,
  output logic [31:0]      HI,
  output logic [31:0]      LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt  = CntW'(DIV_CYCLES);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic [31:0]     p_hi_q, p_hi_d;
  logic [31:0]     p_lo_q, p_lo_d;
  // Cleared for divide-by-zero so the commit leaves HI/LO untouched.
  logic            p_wr_q, p_wr_d;

  md_op_e op;
  assign op = md_op_e'(MDOp);

  // Multiply: sign- or zero-extend to 64 bits; the low 64 bits of the
  // product are correct for both interpretations.
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, product;

  assign mul_signed = (op == MdMult);
  assign mul_a      = {{32{mul_signed & SrcA[31]}}, SrcA};
  assign mul_b      = {{32{mul_signed & SrcB[31]}}, SrcB};
  assign product    = mul_a * mul_b;

  // Divide on magnitudes, then restore signs: quotient truncates toward
  // zero, remainder takes the dividend's sign. 0x80000000 / -1 falls out as
  // quotient 0x80000000, remainder 0 without a special case.
  logic        div_signed, a_neg, b_neg, div_by_zero;
  logic [31:0] a_mag, b_mag, div_b, q_mag, r_mag, quot, rem;

  assign div_signed  = (op == MdDiv);
  assign a_neg       = div_signed & SrcA[31];
  assign b_neg       = div_signed & SrcB[31];
  assign a_mag       = a_neg ? (32'd0 - SrcA) : SrcA;
  assign b_mag       = b_neg ? (32'd0 - SrcB) : SrcB;
  assign div_by_zero = (SrcB == 32'd0);
  assign div_b       = div_by_zero ? 32'd1 : b_mag;
  assign q_mag       = a_mag / div_b;
  assign r_mag       = a_mag % div_b;
  assign quot        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem         = a_neg ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    p_hi_d  = p_hi_q;
    p_lo_d  = p_lo_q;
    p_wr_d  = p_wr_q;

    unique case (state_q)
      StIdle: begin
        if (Start) begin
          case (op)
            MdMult, MdMultu: begin
              {p_hi_d, p_lo_d} = product;
              p_wr_d  = 1'b1;
              cnt_d   = MultCnt;
              busy_d  = 1'b1;
              state_d = StRun;
            end
            MdDiv, MdDivu: begin
              p_hi_d  = rem;
              p_lo_d  = quot;
              p_wr_d  = ~div_by_zero;
              cnt_d   = DivCnt;
              busy_d  = 1'b1;
              state_d = StRun;
            end
            MdMthi:  hi_d = SrcA;
            MdMtlo:  lo_d = SrcA;
            default: ;
          endcase
        end
      end
      StRun: begin
        // Start is deliberately ignored here; the hazard unit stalls MD ops.
        if (cnt_q == CntOne) begin
          if (p_wr_q) begin
            hi_d = p_hi_q;
            lo_d = p_lo_q;
          end
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
      p_wr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      p_hi_q  <= p_hi_d;
      p_lo_q  <= p_lo_d;
      p_wr_q  <= p_wr_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit. Inputs change and outputs are
// sampled on the falling edge, away from the active rising edge.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] SrcA, SrcB;
  logic        Busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(
    .MULT_CYCLES(MultN),
    .DIV_CYCLES (DivN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .Start(Start),
    .MDOp (MDOp),
    .SrcA (SrcA),
    .SrcB (SrcB),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDOp  = op;
    SrcA  = a;
    SrcB  = b;
    @(negedge clk);
    Start = 1'b0;
    MDOp  = MdNone;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Start = 1'b0;
    MDOp  = MdNone;
    SrcA  = '0;
    SrcB  = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      errors++;
      $display("FAIL reset: Busy=%b HI=%h LO=%h want 0/0/0", Busy, HI, LO);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult_signed();
    issue(MdMult, 32'hFFFF_FFFE, 32'd3);
    for (int i = 1; i <= MultN; i++) begin
      checks++;
      if (Busy !== 1'b1 || HI !== 32'h0 || LO !== 32'h0) begin
        errors++;
        $display("FAIL mult_busy cyc%0d: Busy=%b HI=%h LO=%h want 1/0/0", i, Busy, HI, LO);
      end
      @(negedge clk);
    end
    checks++;
    if (Busy !== 1'b0 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_result: Busy=%b HI=%h LO=%h want 0/ffffffff/fffffffa", Busy, HI, LO);
    end
  endtask

  task automatic test_multu();
    issue(MdMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 1; i <= MultN; i++) begin
      checks++;
      if (Busy !== 1'b1 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
        errors++;
        $display("FAIL multu_busy cyc%0d: Busy=%b HI=%h LO=%h", i, Busy, HI, LO);
      end
      @(negedge clk);
    end
    checks++;
    if (Busy !== 1'b0 || HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
      errors++;
      $display("FAIL multu_result: Busy=%b HI=%h LO=%h want 0/fffffffe/00000001", Busy, HI, LO);
    end
  endtask

  task automatic test_div();
    issue(MdDiv, 32'hFFFF_FFF9, 32'd2);
    for (int i = 1; i <= DivN; i++) begin
      checks++;
      if (Busy !== 1'b1 || HI !== 32'hFFFF_FFFE || LO !== 32'h0000_0001) begin
        errors++;
        $display("FAIL div_busy cyc%0d: Busy=%b HI=%h LO=%h", i, Busy, HI, LO);
      end
      @(negedge clk);
    end
    checks++;
    if (Busy !== 1'b0 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_result: Busy=%b HI=%h LO=%h want 0/ffffffff/fffffffd", Busy, HI, LO);
    end
    issue(MdDivu, 32'hFFFF_FFF9, 32'd2);
    repeat (DivN) @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0000_0001 || LO !== 32'h7FFF_FFFC) begin
      errors++;
      $display("FAIL divu_result: Busy=%b HI=%h LO=%h want 0/00000001/7ffffffc", Busy, HI, LO);
    end
    // Signed overflow corner.
    issue(MdDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (DivN) @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_overflow: Busy=%b HI=%h LO=%h want 0/00000000/80000000", Busy, HI, LO);
    end
  endtask

  task automatic test_div_zero();
    issue(MdMthi, 32'h0000_1234, 32'h0);
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0000_1234) begin
      errors++;
      $display("FAIL mthi: Busy=%b HI=%h want 0/00001234", Busy, HI);
    end
    issue(MdMtlo, 32'h0000_5678, 32'h0);
    checks++;
    if (Busy !== 1'b0 || LO !== 32'h0000_5678) begin
      errors++;
      $display("FAIL mtlo: Busy=%b LO=%h want 0/00005678", Busy, LO);
    end
    issue(MdDiv, 32'd5, 32'd0);
    for (int i = 1; i <= DivN; i++) begin
      checks++;
      if (Busy !== 1'b1) begin
        errors++;
        $display("FAIL divzero_busy cyc%0d: Busy=%b want 1", i, Busy);
      end
      @(negedge clk);
    end
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0000_1234 || LO !== 32'h0000_5678) begin
      errors++;
      $display("FAIL divzero_result: Busy=%b HI=%h LO=%h want 0/00001234/00005678", Busy, HI, LO);
    end
  endtask

  task automatic test_undefined_op();
    issue(md_op_e'(4'hF), 32'hDEAD_BEEF, 32'd7);
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0000_1234 || LO !== 32'h0000_5678) begin
      errors++;
      $display("FAIL undef_op: Busy=%b HI=%h LO=%h want 0/00001234/00005678", Busy, HI, LO);
    end
  endtask

  task automatic test_start_while_busy();
    issue(MdMult, 32'd2, 32'd3);
    @(negedge clk);
    issue(MdMtlo, 32'h0000_AAAA, 32'h0);
    checks++;
    if (Busy !== 1'b1 || LO !== 32'h0000_5678) begin
      errors++;
      $display("FAIL busy_drop: Busy=%b LO=%h want 1/00005678", Busy, LO);
    end
    repeat (MultN - 3) @(negedge clk);
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_drop_len: Busy=%b want 1", Busy);
    end
    @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'd6) begin
      errors++;
      $display("FAIL busy_drop_result: Busy=%b HI=%h LO=%h want 0/00000000/00000006", Busy, HI, LO);
    end
  endtask

  task automatic test_reset_abort();
    issue(MdDiv, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      errors++;
      $display("FAIL abort_reset: Busy=%b HI=%h LO=%h want 0/0/0", Busy, HI, LO);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (DivN + 2) @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
      errors++;
      $display("FAIL abort_nocommit: Busy=%b HI=%h LO=%h want 0/0/0", Busy, HI, LO);
    end
    issue(MdMult, 32'd4, 32'd5);
    repeat (MultN) @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'd20) begin
      errors++;
      $display("FAIL abort_newmult: Busy=%b HI=%h LO=%h want 0/00000000/00000014", Busy, HI, LO);
    end
  endtask

  task automatic test_back_to_back();
    issue(MdMult, 32'd3, 32'd3);
    repeat (MultN) @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || LO !== 32'd9) begin
      errors++;
      $display("FAIL b2b_first: Busy=%b LO=%h want 0/00000009", Busy, LO);
    end
    issue(MdMultu, 32'd7, 32'd6);
    checks++;
    if (Busy !== 1'b1 || LO !== 32'd9) begin
      errors++;
      $display("FAIL b2b_accept: Busy=%b LO=%h want 1/00000009", Busy, LO);
    end
    repeat (MultN) @(negedge clk);
    checks++;
    if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'd42) begin
      errors++;
      $display("FAIL b2b_second: Busy=%b HI=%h LO=%h want 0/00000000/0000002a", Busy, HI, LO);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mult_signed();
    test_multu();
    test_div();
    test_div_zero();
    test_undefined_op();
    test_start_while_busy();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
